enemy_sprite_fetch: RTL and testbench
=====================================

ENEMY_SPRITE_FETCH -- requirements
Module: enemy_sprite_fetch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of requesting channels (1..8).
REQ-002 SHALL have parameter RD_LAT, default 1: memory read latency in cycles (1..3).
REQ-003 SHALL have parameter NUM_TYPES, default 6: valid enemy types (1..8).
REQ-004 SHALL have parameter PROJ_BASE, default 49152: projectile sprite base address.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_CH: per-channel request valid.
REQ-008 SHALL have port req_ready, output, NUM_CH: per-channel grant, one-hot or zero.
REQ-009 SHALL have port req_kind, input, NUM_CH: per channel, 0 = enemy, 1 = projectile.
REQ-010 SHALL have port req_flip, input, NUM_CH: per-channel horizontal mirror.
REQ-011 SHALL have port req_type, input, 3*NUM_CH: enemy type per channel.
REQ-012 SHALL have port req_frame, input, 3*NUM_CH: frame 0-7 (0-3 idle, 4-7 walk).
REQ-013 SHALL have port req_x and req_y, input, 5*NUM_CH each: in-sprite pixel coordinates.
REQ-014 SHALL have port mem_addr, output, 16: registered address to sprite BRAM.
REQ-015 SHALL have port mem_data, input, 6: RGB222 BRAM data, valid RD_LAT cycles after mem_addr.
REQ-016 SHALL have port rsp_valid, output, NUM_CH: one-cycle pulse per completed request.
REQ-017 SHALL have port rsp_pixel, output, 6: returned RGB222 pixel.
REQ-018 SHALL have port rsp_transparent, output, 1: pixel equals 6'h33.

Function
REQ-019 Handshake SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1; at most one accept per cycle.
REQ-020 req_ready SHALL be combinational from req_valid and a round-robin pointer; the first requesting channel at or after the pointer wins.
REQ-021 After an accept on channel g the pointer SHALL become (g+1) mod NUM_CH; with no accept it SHALL hold.
REQ-022 Request fields SHALL be sampled only in the accept cycle; the channel may change them afterwards.
REQ-023 Enemy address SHALL be {type, frame, y, x'} = type*8192 + frame*1024 + y*32 + x', with x' = flip ? 31-x : x.
REQ-024 Projectile address SHALL be PROJ_BASE + y[3:0]*16 + x'[3:0], with x' = flip ? 15-x[3:0] : x[3:0]; upper coordinate bits are ignored.
REQ-025 An enemy request with type >= NUM_TYPES SHALL still occupy a pipeline slot, SHALL return rsp_pixel = 6'h33 and rsp_transparent = 1, and SHALL place address 0 on mem_addr.
REQ-026 Latency: accept in cycle 0 -> mem_addr valid in cycle 1 -> mem_data in cycle 1+RD_LAT -> rsp_valid/rsp_pixel registered in cycle 2+RD_LAT.
REQ-027 Valid bit, channel ID and invalid-type flag SHALL travel in a shift pipeline of depth RD_LAT+1 aligned to the data.
REQ-028 Back-to-back accepts SHALL be sustained, giving one response per cycle; responses SHALL be in accept order.
REQ-029 rsp_pixel and rsp_transparent SHALL hold their last values when rsp_valid is all-zero.
REQ-030 No backpressure on responses; the consumer SHALL accept every rsp_valid pulse.

Reset
REQ-031 On reset: req_ready = 0 in the same cycle, pointer = 0, pipeline valids cleared, mem_addr = 0, rsp_valid = 0, rsp_pixel = 0, rsp_transparent = 0.
REQ-032 Requests in flight at reset SHALL be discarded; no rsp_valid for them after reset deasserts.

Structure
REQ-033 Package sprite_pkg SHALL hold TRANSP_COLOR = 6'h33, ENEMY_FRAME_WORDS = 1024, ENEMY_TYPE_WORDS = 8192, PROJ_BASE default, and the req_kind enum.
REQ-034 The round-robin grant and pointer logic SHALL be a sub-module rr_arbiter parametrised by NUM_CH.
REQ-035 Elaboration SHALL fail if PROJ_BASE+255 > 65535 or if NUM_TYPES*8192 > PROJ_BASE.

Verification (NUM_CH=4, RD_LAT=1)
REQ-036 ch2 enemy type 1, frame 3, x=5, y=7, flip=0 -> mem_addr = 11493 in cycle 1; rsp_valid = 4'b0100 in cycle 3.
REQ-037 Same request with flip=1 -> mem_addr = 11514; mem_data = 6'h33 -> rsp_transparent = 1.
REQ-038 ch0 projectile x=15, y=15, flip=0 -> mem_addr = 49407; with flip=1 -> 49392.
REQ-039 All 4 channels held valid 8 cycles -> grants 0,1,2,3,0,1,2,3, then one rsp_valid per cycle in that order.
REQ-040 Enemy type 6 -> rsp_pixel = 6'h33, rsp_transparent = 1, mem_addr = 0.
REQ-041 Accept in cycle 0 with reset asserted in cycle 1 -> rsp_valid stays 0 through cycle 6; pointer = 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants, request record and address helpers for the enemy/projectile sprite fetcher.
// Enemy sprites are packed 8 frames x 32x32 per type; projectiles are one 16x16 tile at a base.
package sprite_pkg;

   localparam logic [5:0] TRANSP_COLOR      = 6'h33;
   localparam int         ENEMY_FRAME_WORDS = 1024;
   localparam int         ENEMY_TYPE_WORDS  = 8192;
   localparam int         PROJ_BASE_DFLT    = 49152;

   typedef enum logic {
      KIND_ENEMY = 1'b0,
      KIND_PROJ  = 1'b1
   } req_kind_e;

   typedef struct packed {
      req_kind_e  kind;
      logic       flip;
      logic [2:0] etype;
      logic [2:0] frame;
      logic [4:0] x;
      logic [4:0] y;
   } sprite_req_t;

   // Field concatenation equals type*ENEMY_TYPE_WORDS + frame*ENEMY_FRAME_WORDS + y*32 + x'.
   function automatic logic [15:0] enemy_addr(input sprite_req_t r);
      logic [4:0] xm;
      xm = r.flip ? ~r.x : r.x;
      return {r.etype, r.frame, r.y, xm};
   endfunction

   function automatic logic [15:0] proj_addr(input sprite_req_t r, input logic [15:0] base);
      logic [3:0] xm;
      xm = r.flip ? ~r.x[3:0] : r.x[3:0];
      return base + {8'h00, r.y[3:0], xm};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; the pointer moves past the winner on every grant.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req_valid_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [PTR_W-1:0]  grant_idx_o,
   output logic              grant_any_o
);

   logic [PTR_W-1:0] ptr_q, ptr_d;

   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int ofs);
      return PTR_W'((int'(base) + ofs) % NUM_CH);
   endfunction

   // Grants are suppressed during reset so nothing is accepted into a pipeline being flushed.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_any_o && req_valid_i[wrap_idx(ptr_q, k)]) begin
               grant_any_o                  = 1'b1;
               grant_idx_o                  = wrap_idx(ptr_q, k);
               grant_o[wrap_idx(ptr_q, k)] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant_any_o) ptr_d = wrap_idx(grant_idx_o, 1);
   end

   always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/enemy_sprite_fetch.sv
// Arbitrates per-channel sprite pixel requests, forms the BRAM address and returns the pixel
// RD_LAT+1 cycles after the address, with channel ID carried alongside in a shift pipeline.
module enemy_sprite_fetch
   import sprite_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int RD_LAT    = 1,
   parameter int NUM_TYPES = 6,
   parameter int PROJ_BASE = PROJ_BASE_DFLT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_CH-1:0]   req_valid,
   output logic [NUM_CH-1:0]   req_ready,
   input  logic [NUM_CH-1:0]   req_kind,
   input  logic [NUM_CH-1:0]   req_flip,
   input  logic [3*NUM_CH-1:0] req_type,
   input  logic [3*NUM_CH-1:0] req_frame,
   input  logic [5*NUM_CH-1:0] req_x,
   input  logic [5*NUM_CH-1:0] req_y,
   output logic [15:0]         mem_addr,
   input  logic [5:0]          mem_data,
   output logic [NUM_CH-1:0]   rsp_valid,
   output logic [5:0]          rsp_pixel,
   output logic                rsp_transparent
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (PROJ_BASE + 255 > 65535) begin : g_bad_proj_base
      $error("PROJ_BASE tile does not fit in the 16-bit address space");
   end
   if (NUM_TYPES * ENEMY_TYPE_WORDS > PROJ_BASE) begin : g_bad_num_types
      $error("enemy sprite region overlaps the projectile tile");
   end
   if (NUM_CH < 1 || NUM_CH > 8 || RD_LAT < 1 || RD_LAT > 3 || NUM_TYPES < 1 || NUM_TYPES > 8)
   begin : g_bad_range
      $error("parameter out of supported range");
   end

   logic [CH_W-1:0] gnt_idx;
   logic            gnt_any;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .grant_o     (req_ready),
      .grant_idx_o (gnt_idx),
      .grant_any_o (gnt_any)
   );

   sprite_req_t acc;
   logic        acc_inv;
   logic [15:0] addr_d;

   always_comb begin
      acc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req_ready[i]) begin
            acc.kind  = req_kind_e'(req_kind[i]);
            acc.flip  = req_flip[i];
            acc.etype = req_type[3*i +: 3];
            acc.frame = req_frame[3*i +: 3];
            acc.x     = req_x[5*i +: 5];
            acc.y     = req_y[5*i +: 5];
         end
      end
   end

   // Out-of-range enemy types still take a slot so response ordering is unaffected.
   always_comb begin
      acc_inv = (acc.kind == KIND_ENEMY) && (32'(acc.etype) >= NUM_TYPES);
      addr_d  = '0;
      if (!acc_inv) begin
         if (acc.kind == KIND_PROJ) addr_d = proj_addr(acc, 16'(PROJ_BASE));
         else                       addr_d = enemy_addr(acc);
      end
   end

   logic [15:0]                mem_addr_q;
   logic [RD_LAT:0]            vld_pipe_q;
   logic [RD_LAT:0]            inv_pipe_q;
   logic [RD_LAT:0][CH_W-1:0]  ch_pipe_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr_q <= '0;
         vld_pipe_q <= '0;
         inv_pipe_q <= '0;
         ch_pipe_q  <= '0;
      end else begin
         if (gnt_any) mem_addr_q <= addr_d;
         vld_pipe_q[0] <= gnt_any;
         inv_pipe_q[0] <= acc_inv;
         ch_pipe_q[0]  <= gnt_idx;
         for (int s = 1; s <= RD_LAT; s++) begin
            vld_pipe_q[s] <= vld_pipe_q[s-1];
            inv_pipe_q[s] <= inv_pipe_q[s-1];
            ch_pipe_q[s]  <= ch_pipe_q[s-1];
         end
      end
   end

   assign mem_addr = mem_addr_q;

   logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
   logic [5:0]        rsp_pixel_q, rsp_pixel_d;
   logic              rsp_transp_q, rsp_transp_d;

   // Stage RD_LAT lines up with mem_data for the same request.
   always_comb begin
      rsp_valid_d  = '0;
      rsp_pixel_d  = rsp_pixel_q;
      rsp_transp_d = rsp_transp_q;
      if (vld_pipe_q[RD_LAT]) begin
         rsp_valid_d  = NUM_CH'(1) << ch_pipe_q[RD_LAT];
         rsp_pixel_d  = inv_pipe_q[RD_LAT] ? TRANSP_COLOR : mem_data;
         rsp_transp_d = (rsp_pixel_d == TRANSP_COLOR);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q  <= '0;
         rsp_pixel_q  <= '0;
         rsp_transp_q <= 1'b0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_pixel_q  <= rsp_pixel_d;
         rsp_transp_q <= rsp_transp_d;
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_pixel       = rsp_pixel_q;
   assign rsp_transparent = rsp_transp_q;

endmodule

// File: tb/tb_enemy_sprite_fetch.sv
// Directed bench for enemy_sprite_fetch (NUM_CH=4, RD_LAT=1) with a one-cycle BRAM model.
module tb_enemy_sprite_fetch;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid, req_ready, req_kind, req_flip;
   logic [11:0] req_type, req_frame;
   logic [19:0] req_x, req_y;
   logic [15:0] mem_addr;
   logic [5:0]  mem_data;
   logic [3:0]  rsp_valid;
   logic [5:0]  rsp_pixel;
   logic        rsp_transparent;

   int n_chk = 0;
   int n_err = 0;

   enemy_sprite_fetch #(.NUM_CH(4), .RD_LAT(1), .NUM_TYPES(6), .PROJ_BASE(49152)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_flip(req_flip),
      .req_type(req_type), .req_frame(req_frame), .req_x(req_x), .req_y(req_y),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .rsp_valid(rsp_valid), .rsp_pixel(rsp_pixel), .rsp_transparent(rsp_transparent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sprite BRAM contents: one location holds the transparent key, the rest a simple hash.
   function automatic logic [5:0] mem_fn(input logic [15:0] a);
      if (a == 16'd11514) return 6'h33;
      return a[5:0] ^ 6'h2A;
   endfunction

   always @(posedge clk) mem_data <= mem_fn(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int ch, input logic kind, input logic flip, input logic [2:0] typ,
                          input logic [2:0] frame, input logic [4:0] x, input logic [4:0] y);
      req_kind[ch]        = kind;
      req_flip[ch]        = flip;
      req_type[3*ch +: 3]  = typ;
      req_frame[3*ch +: 3] = frame;
      req_x[5*ch +: 5]     = x;
      req_y[5*ch +: 5]     = y;
      req_valid[ch]       = 1'b1;
   endtask

   // Called on a falling edge: accept in cycle 0, address in cycle 1, response in cycle 3.
   task automatic single(input string tag, input int ch, input logic kind, input logic flip,
                         input logic [2:0] typ, input logic [2:0] frame, input logic [4:0] x,
                         input logic [4:0] y, input logic [15:0] exp_addr, input logic [5:0] exp_pix);
      set_req(ch, kind, flip, typ, frame, x, y);
      #1 chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << ch));
      @(negedge clk);
      req_valid = '0;
      #1 chk({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({tag, ".novld1"}, 32'(rsp_valid), 0);
      @(negedge clk);
      #1 chk({tag, ".novld2"}, 32'(rsp_valid), 0);
      @(negedge clk);
      #1 chk({tag, ".rspvld"}, 32'(rsp_valid), 32'(4'b0001 << ch));
      chk({tag, ".pix"}, 32'(rsp_pixel), 32'(exp_pix));
      chk({tag, ".transp"}, 32'(rsp_transparent), 32'(exp_pix == 6'h33));
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_kind = '0; req_flip = '0;
      req_type = '0; req_frame = '0; req_x = '0; req_y = '0;
      repeat (2) @(negedge clk);
      req_valid = 4'hF;
      #1 chk("rst.ready", 32'(req_ready), 0);
      chk("rst.addr", 32'(mem_addr), 0);
      chk("rst.rspvld", 32'(rsp_valid), 0);
      chk("rst.pix", 32'(rsp_pixel), 0);
      chk("rst.transp", 32'(rsp_transparent), 0);
      @(negedge clk);
      req_valid = '0;
      reset = 1'b0;
      @(negedge clk);

      // enemy type 1 frame 3 (x=5,y=7): 8192+3072+224+5
      single("enemy", 2, 1'b0, 1'b0, 3'd1, 3'd3, 5'd5, 5'd7, 16'd11493, mem_fn(16'd11493));
      @(negedge clk);
      // mirrored: x'=26 lands on the transparent key; pointer at 3 wraps back to ch2
      single("flip", 2, 1'b0, 1'b1, 3'd1, 3'd3, 5'd5, 5'd7, 16'd11514, 6'h33);
      @(negedge clk);
      #1 chk("hold.vld", 32'(rsp_valid), 0);
      chk("hold.pix", 32'(rsp_pixel), 32'h33);
      chk("hold.transp", 32'(rsp_transparent), 1);

      single("proj", 0, 1'b1, 1'b0, 3'd0, 3'd0, 5'd15, 5'd15, 16'd49407, mem_fn(16'd49407));
      @(negedge clk);
      // upper coordinate bits ignored, flip gives x'=0
      single("projflip", 0, 1'b1, 1'b1, 3'd0, 3'd0, 5'd31, 5'd15, 16'd49392, mem_fn(16'd49392));
      @(negedge clk);
      single("badtype", 1, 1'b0, 1'b0, 3'd6, 3'd2, 5'd3, 5'd4, 16'd0, 6'h33);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // all channels requesting: enemy type i, frame i, x=i, y=i -> address i*9249
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 3'(i), 3'(i), 5'(i), 5'(i));
      for (int k = 0; k <= 10; k++) begin
         req_valid = (k < 8) ? 4'hF : 4'h0;
         #1;
         if (k < 8) chk($sformatf("rr.ready%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         if (k >= 1 && k <= 8) chk($sformatf("rr.addr%0d", k), 32'(mem_addr), ((k - 1) % 4) * 9249);
         if (k < 3) chk($sformatf("rr.novld%0d", k), 32'(rsp_valid), 0);
         else begin
            chk($sformatf("rr.rspvld%0d", k), 32'(rsp_valid), 32'(4'b0001 << ((k - 3) % 4)));
            chk($sformatf("rr.pix%0d", k), 32'(rsp_pixel),
                32'(mem_fn(16'(((k - 3) % 4) * 9249))));
         end
         @(negedge clk);
      end

      // in-flight request discarded by reset one cycle after accept
      set_req(1, 1'b0, 1'b0, 3'd2, 3'd1, 5'd9, 5'd9);
      #1 chk("flush.ready", 32'(req_ready), 32'h2);
      @(negedge clk);
      reset = 1'b1;
      req_valid = 4'hF;
      #1 chk("flush.rstready", 32'(req_ready), 0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = '0;
      for (int c = 2; c <= 6; c++) begin
         #1 chk($sformatf("flush.novld%0d", c), 32'(rsp_valid), 0);
         @(negedge clk);
      end
      req_valid = 4'hF;
      #1 chk("flush.ptr0", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
